decoder_scan_sequencer: RTL

//  Drives the select (A,B,C) and enable (G1,G2A,G2B) inputs of the 3-to-8 binary_decoder.

---
 rtl/decoder_scan_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: round-robin scan of masked channels onto a 3-to-8 decoder with dwell and blanking gap
module decoder_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] mask,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       G1,
  output logic       G2A,
  output logic       G2B,
  output logic [2:0] chan,
  output logic       slot_start,
  output logic       busy
);
  localparam int MX = DWELL > BLANK ? DWELL : BLANK;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] DL = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL = CW'(BLANK - 1);
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_BLANK} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] sel, sel_n, first, nxt;
  logic start_n, step, g1_n, busy_n;
  assign {C, B, A} = sel;
  assign chan = sel;
  // register state, counter, select and all decoder-facing outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      sel <= '0;
      slot_start <= 1'b0;
      G1 <= 1'b0;
      G2A <= 1'b1;
      G2B <= 1'b1;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sel <= sel_n;
      slot_start <= start_n;
      G1 <= g1_n;
      G2A <= ~g1_n;
      G2B <= ~g1_n;
      busy <= busy_n;
    end
  end
  // lowest set mask bit, and first set bit above the current channel with wrap
  always_comb begin
    first = '0;
    nxt = sel;
    for (int i = 7; i >= 0; i--) if (mask[i]) first = 3'(i);
    for (int i = 7; i >= 1; i--) if (mask[3'(int'(sel) + i)]) nxt = 3'(int'(sel) + i);
  end
  // next state: dwell, optional blank, then advance; en low aborts to idle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sel_n = sel;
    start_n = 1'b0;
    step = 1'b0;
    case (state)
      S_IDLE: if (mask != 8'h00) begin
        state_n = S_DRIVE;
        sel_n = first;
        cnt_n = '0;
        start_n = 1'b1;
      end
      S_DRIVE: if (cnt == DL) begin
        if (BLANK > 0) begin
          state_n = S_BLANK;
          cnt_n = '0;
        end else step = 1'b1;
      end else cnt_n = cnt + CW'(1);
      S_BLANK: if (cnt == BL) step = 1'b1; else cnt_n = cnt + CW'(1);
      default: state_n = S_IDLE;
    endcase
    if (step) begin
      state_n = mask == 8'h00 ? S_IDLE : S_DRIVE;
      sel_n = mask == 8'h00 ? sel : nxt;
      cnt_n = '0;
      start_n = mask != 8'h00;
    end
    if (!en) begin
      state_n = S_IDLE;
      cnt_n = '0;
      sel_n = sel;
      start_n = 1'b0;
    end
  end
  // decoder enables and busy follow the upcoming state so they register alongside it
  always_comb begin
    g1_n = state_n == S_DRIVE;
    busy_n = state_n != S_IDLE;
  end
endmodule
